// File: rtl/matrix_decompiler_pkg.sv
// -----------------------------------------------------------------------------
// matrix_pkg
// Shared types and sizing for the matrix receive path.
//   DEF_*               : default geometry used by matrix_decompiler parameters
//   DIBITS_PER_ELEMENT  : dibits per element at the default element width
//   ELEMENTS_PER_MATRIX : elements per frame at the default geometry
//   state_t             : frame FSM states {IDLE, RECEIVE, DRAIN}
//   cnt_width()         : counter width that never collapses to zero bits
// -----------------------------------------------------------------------------
package matrix_pkg;

    localparam int unsigned DEF_ELEMENT_SIZE    = 8;
    localparam int unsigned DEF_SIZE_A          = 32;
    localparam int unsigned DEF_SIZE_B          = 32;
    localparam int unsigned DEF_GAP_TIMEOUT     = 64;

    localparam int unsigned DIBITS_PER_ELEMENT  = DEF_ELEMENT_SIZE / 2;
    localparam int unsigned ELEMENTS_PER_MATRIX = DEF_SIZE_A * DEF_SIZE_B;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECEIVE = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/matrix_decompiler_elem_fifo.sv
// -----------------------------------------------------------------------------
// elem_fifo
// Two-entry first-word-fall-through FIFO holding {index, element} words.
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_flush        : synchronous clear of all entries (same effect as reset)
//   i_push/data    : write request; accepted when not full or popping this cycle
//   i_pop          : read request; ignored when empty
//   o_pop_data     : head entry, valid whenever o_empty is low
//   o_full/o_empty : occupancy flags
// -----------------------------------------------------------------------------
module elem_fifo #(
    parameter int unsigned WIDTH = 18
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_data,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr;
    logic             r_rd;
    logic [1:0]       r_cnt;
    logic             w_push;
    logic             w_pop;

    assign o_full     = (r_cnt == 2'd2);
    assign o_empty    = (r_cnt == 2'd0);
    assign o_pop_data = r_mem[r_rd];

    assign w_pop  = i_pop && !o_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_wr  <= 1'b0;
            r_rd  <= 1'b0;
            r_cnt <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= i_push_data;
                r_wr        <= ~r_wr;
            end
            if (w_pop) begin
                r_rd <= ~r_rd;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/matrix_decompiler.sv
// -----------------------------------------------------------------------------
// matrix_decompiler
// Reassembles a row-major, MSB-first dibit stream into addressed matrix
// elements, one MAX_SIZE_A x MAX_SIZE_B matrix per frame.
//   inter_refclk, rst       : clock, synchronous active-high reset
//   dibit, dibit_valid      : incoming dibit stream
//   elem_ready, elem_valid  : output handshake (FWFT FIFO not-empty)
//   row_addr, col_addr      : element address (upper/lower index bits)
//   matrix_element          : element value
//   matrix_done             : pulse after the last element of a frame is popped
//   overflow_err            : sticky, an element was dropped on a full FIFO
//   timeout_err             : pulse when a frame is aborted by a dibit gap
// Optional feature: define MATRIX_DECOMPILER_TIMEOUT_EN to enable the
// inter-dibit gap timeout; otherwise timeout_err is tied low.
// -----------------------------------------------------------------------------
module matrix_decompiler
    import matrix_pkg::*;
#(
    parameter int unsigned MAX_ELEMENT_SIZE = DEF_ELEMENT_SIZE,
    parameter int unsigned MAX_SIZE_A       = DEF_SIZE_A,
    parameter int unsigned MAX_SIZE_B       = DEF_SIZE_B,
    parameter int unsigned GAP_TIMEOUT      = DEF_GAP_TIMEOUT
) (
    input  logic                          inter_refclk,
    input  logic                          rst,
    input  logic [1:0]                    dibit,
    input  logic                          dibit_valid,
    input  logic                          elem_ready,
    output logic                          elem_valid,
    output logic [$clog2(MAX_SIZE_A)-1:0] row_addr,
    output logic [$clog2(MAX_SIZE_B)-1:0] col_addr,
    output logic [MAX_ELEMENT_SIZE-1:0]   matrix_element,
    output logic                          matrix_done,
    output logic                          overflow_err,
    output logic                          timeout_err
);

    localparam int unsigned DPE = MAX_ELEMENT_SIZE / 2;
    localparam int unsigned EPM = MAX_SIZE_A * MAX_SIZE_B;
    localparam int unsigned RW  = $clog2(MAX_SIZE_A);
    localparam int unsigned CW  = $clog2(MAX_SIZE_B);
    localparam int unsigned IW  = RW + CW;
    localparam int unsigned DCW = cnt_width(DPE);
    localparam int unsigned FW  = MAX_ELEMENT_SIZE + IW;

    state_t                      r_state;
    state_t                      w_next_state;
    logic [DCW-1:0]              r_dcnt;
    logic [IW-1:0]               r_idx;
    logic [MAX_ELEMENT_SIZE-1:0] r_shift;
    logic [MAX_ELEMENT_SIZE-1:0] w_assembled;
    logic                        r_done;
    logic                        r_overflow;
    logic                        w_accept;
    logic                        w_elem_done;
    logic                        w_last_elem;
    logic                        w_push;
    logic                        w_pop;
    logic                        w_drop;
    logic                        w_full;
    logic                        w_empty;
    logic                        w_done_set;
    logic                        w_abort;
    logic [FW-1:0]               w_fifo_out;

    assign w_accept    = dibit_valid && (r_state != DRAIN);
    assign w_elem_done = w_accept && (r_dcnt == DCW'(DPE - 1));
    assign w_last_elem = (r_idx == IW'(EPM - 1));
    assign w_pop       = !w_empty && elem_ready;
    assign w_push      = w_elem_done && (!w_full || w_pop);
    assign w_drop      = w_elem_done && w_full && !w_pop;
    // Nothing is pushed in DRAIN, so a pop with one entry left empties it.
    assign w_done_set  = (r_state == DRAIN) && w_pop && !w_full;

    // MSB-first: earlier dibits move up as each new dibit enters at the bottom.
    assign w_assembled = (r_shift << 2) | MAX_ELEMENT_SIZE'(dibit);

`ifdef MATRIX_DECOMPILER_TIMEOUT_EN
    localparam int unsigned GW = $clog2(GAP_TIMEOUT + 1);

    logic [GW-1:0] r_gap;
    logic          r_timeout;

    // Fires on the idle cycle that would bring the gap count to GAP_TIMEOUT.
    assign w_abort = (r_state == RECEIVE) && !dibit_valid &&
                     (r_gap == GW'(GAP_TIMEOUT - 1));

    always_ff @(posedge inter_refclk) begin
        if (rst) begin
            r_gap     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_abort;
            if ((r_state != RECEIVE) || dibit_valid || w_abort) begin
                r_gap <= '0;
            end else begin
                r_gap <= r_gap + GW'(1);
            end
        end
    end

    assign timeout_err = r_timeout;
`else
    assign w_abort     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge inter_refclk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = (w_elem_done && w_last_elem) ? DRAIN : RECEIVE;
                end
            end
            RECEIVE: begin
                if (w_abort) begin
                    w_next_state = IDLE;
                end else if (w_elem_done && w_last_elem) begin
                    w_next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (w_done_set) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Index advances even when the element is dropped, keeping later
    // addresses aligned with their position in the frame.
    always_ff @(posedge inter_refclk) begin
        if (rst) begin
            r_dcnt     <= '0;
            r_idx      <= '0;
            r_shift    <= '0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_done <= w_done_set;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_abort) begin
                r_dcnt  <= '0;
                r_idx   <= '0;
                r_shift <= '0;
            end else if (w_accept) begin
                r_shift <= w_assembled;
                if (w_elem_done) begin
                    r_dcnt <= '0;
                    r_idx  <= w_last_elem ? '0 : r_idx + IW'(1);
                end else begin
                    r_dcnt <= r_dcnt + DCW'(1);
                end
            end
        end
    end

    elem_fifo #(
        .WIDTH (FW)
    ) u_fifo (
        .i_clk       (inter_refclk),
        .i_rst       (rst),
        .i_flush     (w_abort),
        .i_push      (w_push),
        .i_push_data ({r_idx, w_assembled}),
        .i_pop       (w_pop),
        .o_pop_data  (w_fifo_out),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    assign elem_valid     = !w_empty;
    assign row_addr       = w_fifo_out[FW-1 -: RW];
    assign col_addr       = w_fifo_out[MAX_ELEMENT_SIZE +: CW];
    assign matrix_element = w_fifo_out[MAX_ELEMENT_SIZE-1:0];
    assign matrix_done    = r_done;
    assign overflow_err   = r_overflow;

endmodule

// File: tb/tb_matrix_decompiler.sv
// -----------------------------------------------------------------------------
// tb_matrix_decompiler
// Scoreboard bench for matrix_decompiler at default geometry (8-bit, 32x32).
// Expected elements are queued as dibits are driven; a negedge monitor pops
// and compares on every elem_valid && elem_ready.
// -----------------------------------------------------------------------------
module tb_matrix_decompiler;

    logic       inter_refclk = 1'b0;
    logic       rst;
    logic [1:0] dibit;
    logic       dibit_valid;
    logic       elem_ready;
    logic       elem_valid;
    logic [4:0] row_addr;
    logic [4:0] col_addr;
    logic [7:0] matrix_element;
    logic       matrix_done;
    logic       overflow_err;
    logic       timeout_err;

    typedef struct packed {
        logic [4:0] row;
        logic [4:0] col;
        logic [7:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks   = 0;
    int   n_pass     = 0;
    int   done_cnt   = 0;
    int   tmo_cnt    = 0;
    int   ready_mode = 0;   // 0: always ready, 1: random ~30%, 2: driven by main
    int   skip_idx   = -1;  // element index expected to be dropped

    always #5 inter_refclk = ~inter_refclk;

    matrix_decompiler #(
        .MAX_ELEMENT_SIZE (8),
        .MAX_SIZE_A       (32),
        .MAX_SIZE_B       (32),
        .GAP_TIMEOUT      (64)
    ) dut (
        .inter_refclk   (inter_refclk),
        .rst            (rst),
        .dibit          (dibit),
        .dibit_valid    (dibit_valid),
        .elem_ready     (elem_ready),
        .elem_valid     (elem_valid),
        .row_addr       (row_addr),
        .col_addr       (col_addr),
        .matrix_element (matrix_element),
        .matrix_done    (matrix_done),
        .overflow_err   (overflow_err),
        .timeout_err    (timeout_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    endtask

    function automatic logic [7:0] elem_val(input int kind, input int idx);
        logic [31:0] v;
        v = idx;
        if (kind == 1 && idx == 0) return 8'hB1;
        return v[7:0];
    endfunction

    // Drives dibits [first, first+n) of a frame, one per cycle.
    task automatic send_dibits(input int kind, input int first, input int n);
        for (int d = first; d < first + n; d++) begin
            logic [31:0] e;
            int          k;
            logic [7:0]  v;
            e = d / 4;
            k = d % 4;
            v = elem_val(kind, d / 4);
            if (k == 0 && int'(e) != skip_idx) exp_q.push_back({e[9:5], e[4:0], v});
            dibit       = v[7-2*k -: 2];
            dibit_valid = 1'b1;
            @(posedge inter_refclk); #1;
        end
        dibit_valid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        for (int c = 0; c < 400 && done_cnt < target; c++) begin
            @(posedge inter_refclk); #1;
        end
        repeat (5) @(posedge inter_refclk);
        #1;
        check("done_count", 32'(done_cnt), 32'(target));
        check("queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor / scoreboard
    always @(negedge inter_refclk) begin
        if (rst === 1'b0) begin
            if (matrix_done) done_cnt++;
            if (timeout_err) tmo_cnt++;
            if (elem_valid && elem_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_elem: got row %0d col %0d val 0x%0h, expected none",
                             row_addr, col_addr, matrix_element);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("elem", 32'({row_addr, col_addr, matrix_element}), 32'(e));
                end
            end
        end
    end

    // elem_ready driver; random mode never holds ready low more than 3 cycles
    initial begin
        int lowrun;
        lowrun     = 0;
        elem_ready = 1'b1;
        forever begin
            @(posedge inter_refclk); #1;
            if (ready_mode == 0) begin
                elem_ready = 1'b1;
            end else if (ready_mode == 1) begin
                if (lowrun >= 3 || $urandom_range(0, 99) < 30) begin
                    elem_ready = 1'b1;
                    lowrun     = 0;
                end else begin
                    elem_ready = 1'b0;
                    lowrun++;
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        dibit       = 2'b00;
        dibit_valid = 1'b0;
        repeat (3) @(posedge inter_refclk);
        #1;
        check("reset_outputs",
              32'({elem_valid, matrix_done, overflow_err, timeout_err,
                   row_addr, col_addr, matrix_element}), 32'd0);
        rst = 1'b0;
        @(posedge inter_refclk); #1;

        // Full frame, value = index
        send_dibits(0, 0, 4096);
        wait_done(1);
        check("t1_overflow", 32'(overflow_err), 32'd0);
        check("t1_timeout", 32'(tmo_cnt), 32'd0);

        // First element from dibits 10,11,00,01 -> 0xB1
        send_dibits(1, 0, 4096);
        wait_done(2);

        // Back-pressure: two buffered, third dropped
        ready_mode = 2;
        elem_ready = 1'b0;
        skip_idx   = 2;
        send_dibits(0, 0, 12);
        check("t3_overflow_set", 32'(overflow_err), 32'd1);
        check("t3_buffered_head", 32'({elem_valid, row_addr, col_addr, matrix_element}),
              32'({1'b1, 5'd0, 5'd0, 8'h00}));
        elem_ready = 1'b1;
        ready_mode = 0;
        send_dibits(0, 12, 4096 - 12);
        skip_idx = -1;
        wait_done(3);
        check("t3_overflow_sticky", 32'(overflow_err), 32'd1);

        // Mid-frame gap of more than GAP_TIMEOUT cycles
        send_dibits(0, 0, 10);
        repeat (70) @(posedge inter_refclk);
        #1;
        check("t4_valid_low", 32'(elem_valid), 32'd0);
`ifdef MATRIX_DECOMPILER_TIMEOUT_EN
        check("t4_timeout_pulses", 32'(tmo_cnt), 32'd1);
        send_dibits(0, 0, 4096);
`else
        check("t4_no_timeout", 32'(tmo_cnt), 32'd0);
        send_dibits(0, 10, 4096 - 10);
`endif
        wait_done(4);

        // Reset mid-frame, then a clean frame
        send_dibits(0, 0, 500);
        rst = 1'b1;
        repeat (2) @(posedge inter_refclk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        check("t5_overflow_cleared", 32'(overflow_err), 32'd0);
        check("t5_valid_cleared", 32'(elem_valid), 32'd0);
        send_dibits(0, 0, 4096);
        wait_done(5);

        // Random ready (~30%) with continuous input
        ready_mode = 1;
        send_dibits(0, 0, 4096);
        wait_done(6);
        ready_mode = 0;
        check("t6_overflow", 32'(overflow_err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
